prime_scanner: RTL and testbench

- Sequencer that sweeps a 4-bit candidate range [lo, hi] through the team's 4-bit prime-detect function and streams out each prime found.
- Results leave on a valid/ready handshake, followed by a one-cycle done pulse carrying the prime count.
- Sits between a host/test controller and downstream consumers of prime values.
- Prime set follows the existing detector definition: {1,2,3,5,7,11,13}. With INCLUDE_ONE=0, 1 is excluded.

---
 rtl/prime_scanner.sv | 149 ++++++++++++++
 tb/tb_prime_scanner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_scanner.sv
// prime_scanner: sweeps a 4-bit candidate range [lo, hi] through the 4-bit
// prime detector and streams each prime on a valid/ready handshake. A
// one-cycle done pulse carrying the transfer count closes every sweep.
module prime_scanner #(
    parameter int INCLUDE_ONE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic       abort,
    output logic       busy,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready,
    output logic       done,
    output logic [3:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;

    // Candidate is one bit wider than the range so that hi=15 can be
    // compared against without the counter wrapping back to 0.
    logic [4:0] cand;
    logic [4:0] cand_nx;
    logic [3:0] end_q;
    logic [3:0] end_nx;
    logic [3:0] count_nx;
    logic [3:0] data_nx;

    logic       cand_prime;
    logic       at_end;

    // Detector-compatible prime set {1,2,3,5,7,11,13}; 1 is optional.
    function automatic logic is_prime(input logic [3:0] v);
        logic p;
        case (v)
            4'd1:    p = (INCLUDE_ONE != 0);
            4'd2,
            4'd3,
            4'd5,
            4'd7,
            4'd11,
            4'd13:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Only the low nibble is tested; cand[4] stays clear in a legal sweep.
    assign cand_prime = is_prime(cand[3:0]);
    assign at_end     = (cand == {1'b0, end_q});

    // Outputs decode directly from the registered state, so an async reset
    // clears them immediately and they never glitch on input changes.
    assign busy      = (state == SCAN) || (state == EMIT);
    assign out_valid = (state == EMIT);
    assign done      = (state == DONE);

    // State and sweep registers; everything clears on async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cand     <= 5'd0;
            end_q    <= 4'd0;
            count    <= 4'd0;
            out_data <= 4'd0;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            end_q    <= end_nx;
            count    <= count_nx;
            out_data <= data_nx;
        end
    end

    // Next-state and datapath updates; abort overrides every transition
    // and leaves count at its partial value.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        end_nx   = end_q;
        count_nx = count;
        data_nx  = out_data;

        if (abort) begin
            // A transfer coinciding with abort is deliberately not counted.
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_nx = 4'd0;
                        if (lo <= hi) begin
                            state_nx = SCAN;
                            cand_nx  = {1'b0, lo};
                            end_nx   = hi;
                        end else begin
                            // Empty range: report an immediate zero-count sweep.
                            state_nx = DONE;
                        end
                    end
                end

                SCAN: begin
                    if (cand_prime) begin
                        state_nx = EMIT;
                        data_nx  = cand[3:0];
                    end else if (at_end) begin
                        state_nx = DONE;
                    end else begin
                        cand_nx = cand + 5'd1;
                    end
                end

                EMIT: begin
                    // out_data is only rewritten in SCAN, so it holds under backpressure.
                    if (out_ready) begin
                        count_nx = count + 4'd1;
                        if (at_end) begin
                            state_nx = DONE;
                        end else begin
                            state_nx = SCAN;
                            cand_nx  = cand + 5'd1;
                        end
                    end
                end

                DONE: begin
                    state_nx = IDLE;
                end

                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_scanner.sv
// tb_prime_scanner: directed scoreboard bench for prime_scanner. Expected
// primes are queued before each sweep and popped on every transfer.
module tb_prime_scanner;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start_b;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       abort;
    logic       out_ready;

    logic       busy,      busy_b;
    logic       out_valid, out_valid_b;
    logic [3:0] out_data,  out_data_b;
    logic       done,      done_b;
    logic [3:0] count,     count_b;

    int exp_q[$];
    int n_cmp;
    int n_bad;

    prime_scanner #(.INCLUDE_ONE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .count     (count)
    );

    prime_scanner #(.INCLUDE_ONE(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .lo        (lo),
        .hi        (hi),
        .abort     (abort),
        .busy      (busy_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_ready (out_ready),
        .done      (done_b),
        .count     (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [3:0] d);
        int e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, {4'b0, d}, 8'hFF);
        end else begin
            e = exp_q.pop_front();
            check(tag, {4'b0, d}, 8'(e));
        end
    endtask

    // Called on a negedge: launch a sweep on the selected instance.
    task automatic kick(input logic [3:0] l, input logic [3:0] h, input bit alt);
        lo = l;
        hi = h;
        if (alt) start_b = 1'b1;
        else     start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    // Collect transfers until done, then check the count and the idle state.
    task automatic drain(input bit alt, input logic [3:0] exp_cnt, input int budget,
                         output int cyc_done);
        logic       v;
        logic [3:0] d;
        logic       dn;
        logic [3:0] cn;
        bit         seen;
        seen     = 1'b0;
        cyc_done = -1;
        for (int c = 0; c < budget; c++) begin
            v  = alt ? out_valid_b : out_valid;
            d  = alt ? out_data_b  : out_data;
            dn = alt ? done_b      : done;
            cn = alt ? count_b     : count;
            if (dn) begin
                check("done_count", {4'b0, cn}, {4'b0, exp_cnt});
                cyc_done = c;
                seen     = 1'b1;
                break;
            end
            if (v && out_ready) pop_check("stream_data", d);
            @(negedge clk);
        end
        check("done_seen", {7'b0, seen}, 8'd1);
        check("queue_empty", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
        @(negedge clk);
        check("done_one_cycle", {7'b0, (alt ? done_b : done)}, 8'd0);
        check("busy_after_done", {7'b0, (alt ? busy_b : busy)}, 8'd0);
        check("valid_after_done", {7'b0, (alt ? out_valid_b : out_valid)}, 8'd0);
        check("count_held", {4'b0, (alt ? count_b : count)}, {4'b0, exp_cnt});
    endtask

    initial begin
        int  c;
        bit  found;
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        start_b   = 1'b0;
        lo        = 4'd0;
        hi        = 4'd0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values on both instances.
        check("rst_valid", {7'b0, out_valid}, 8'd0);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_done", {7'b0, done}, 8'd0);
        check("rst_count", {4'b0, count}, 8'd0);
        check("rst_data", {4'b0, out_data}, 8'd0);
        check("rst_valid_b", {7'b0, out_valid_b}, 8'd0);
        check("rst_busy_b", {7'b0, busy_b}, 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full range with 1 reported as prime; hi=15 must not wrap.
        exp_q = {1, 2, 3, 5, 7, 11, 13};
        out_ready = 1'b1;
        kick(4'd0, 4'd15, 1'b0);
        drain(1'b0, 4'd7, 60, c);

        // Full range with 1 excluded.
        exp_q = {2, 3, 5, 7, 11, 13};
        kick(4'd0, 4'd15, 1'b1);
        drain(1'b1, 4'd6, 60, c);

        // Backpressure: 5 must be held for five stalled cycles.
        exp_q = {5, 7};
        out_ready = 1'b0;
        kick(4'd4, 4'd8, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_valid_seen", {7'b0, found}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", {7'b0, out_valid}, 8'd1);
            check("bp_data_held", {4'b0, out_data}, 8'd5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain(1'b0, 4'd2, 60, c);

        // Single non-prime candidate.
        kick(4'd9, 4'd9, 1'b0);
        drain(1'b0, 4'd0, 60, c);
        check("np_single_latency_ok", {7'b0, (c >= 0 && c <= 3)}, 8'd1);

        // Inverted range reaches done right after the start edge.
        kick(4'd10, 4'd3, 1'b0);
        drain(1'b0, 4'd0, 60, c);
        check("inverted_latency", 8'(c), 8'd0);

        // Single prime candidate.
        exp_q = {13};
        kick(4'd13, 4'd13, 1'b0);
        drain(1'b0, 4'd1, 60, c);

        // Abort while 3 is offered with out_ready high.
        exp_q = {1, 2};
        kick(4'd0, 4'd15, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                if (out_data == 4'd3) begin
                    found = 1'b1;
                    break;
                end
                pop_check("abort_stream", out_data);
            end
            @(negedge clk);
        end
        check("abort_reached_3", {7'b0, found}, 8'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {7'b0, out_valid}, 8'd0);
        check("abort_busy", {7'b0, busy}, 8'd0);
        check("abort_done", {7'b0, done}, 8'd0);
        check("abort_count", {4'b0, count}, 8'd2);
        check("abort_queue", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
        @(negedge clk);
        check("abort_no_done_later", {7'b0, done}, 8'd0);
        check("abort_count_kept", {4'b0, count}, 8'd2);

        // A start pulse during SCAN must not restart the sweep.
        exp_q = {11};
        kick(4'd8, 4'd12, 1'b0);
        lo    = 4'd0;
        hi    = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("scan_busy", {7'b0, busy}, 8'd1);
        drain(1'b0, 4'd1, 60, c);

        // Async reset between edges while 5 is stalled in EMIT.
        exp_q = {1, 2, 3};
        kick(4'd0, 4'd15, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                if (out_data == 4'd5) begin
                    out_ready = 1'b0;
                    found     = 1'b1;
                    break;
                end
                pop_check("pre_reset_stream", out_data);
            end
            @(negedge clk);
        end
        check("pre_reset_reached_5", {7'b0, found}, 8'd1);
        check("pre_reset_count", {4'b0, count}, 8'd3);
        exp_q.delete();
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", {7'b0, out_valid}, 8'd0);
        check("async_busy", {7'b0, busy}, 8'd0);
        check("async_count", {4'b0, count}, 8'd0);
        check("async_data", {4'b0, out_data}, 8'd0);
        check("async_done", {7'b0, done}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q = {1, 2, 3};
        out_ready = 1'b1;
        kick(4'd0, 4'd3, 1'b0);
        drain(1'b0, 4'd3, 60, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
